// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//
// Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e : sequencer FSM state encoding (also driven on the debug port)
//   InstrWidth    : width of an instruction word
//   PcStep        : byte distance between sequential instructions
//   NopInstr      : canonical NOP encoding (addi x0, x0, 0)
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } fetch_state_e;

  localparam int unsigned InstrWidth = 32;
  localparam int unsigned PcStep     = 4;
  localparam logic [InstrWidth-1:0] NopInstr = 32'h0000_0013;

endpackage : fetch_pkg

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
//
// Address-wide register with load enable. Used for both the program counter
// and the pending flush target.
//
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous reset, active-low; q_o returns to ResetVector
//   load_i  : capture d_i on the next rising edge
//   d_i     : next value
//   q_o     : current value
// -----------------------------------------------------------------------------
module pc_reg #(
  parameter int unsigned            DataWidth   = 32,
  parameter logic [DataWidth-1:0]   ResetVector = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [DataWidth-1:0] d_i,
  output logic [DataWidth-1:0] q_o
);

  logic [DataWidth-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= ResetVector;
    end else if (load_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule : pc_reg

// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Owns the program counter and fetches one instruction at a time from the
// instruction memory, handing each to the core before advancing the PC.
// Next-PC priority is trap > redirect > sequential (pc + PcStep, wrapping).
//
// Handshakes (valid/ready semantics):
//   imem request : imem_req_o/imem_addr_o are held stable until imem_gnt_i is
//                  sampled high; a request is accepted on that edge. Exactly one
//                  transaction is outstanding, completed by one imem_rvalid_i.
//   core delivery: instr_valid_o/instr_o/instr_pc_o are held stable until
//                  instr_ready_i is sampled high while instr_valid_o is high.
//
// Ports:
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   imem_req_o/addr_o      : fetch request and word-aligned address
//   imem_gnt_i             : request accepted this cycle
//   imem_rvalid_i/rdata_i  : fetch response (ignored outside WAIT)
//   instr_valid_o/instr_o/instr_pc_o : instruction offered to the core
//   instr_ready_i          : core consumes the instruction
//   redirect_i/redirect_pc_i : taken branch/jump and its target
//   trap_i                 : trap request, target is TrapVector
//   halt_i                 : stop fetching (sampled in IDLE and at handshake)
//   halted_o               : sequencer is halted until reset
//   dbg_state_o            : current FSM state, for observation only
// -----------------------------------------------------------------------------
module pc_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] ResetVector = '0,
  parameter logic [DataWidth-1:0] TrapVector  = DataWidth'(32'h0000_0100)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  imem_req_o,
  output logic [DataWidth-1:0]  imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [InstrWidth-1:0] imem_rdata_i,
  output logic                  instr_valid_o,
  output logic [InstrWidth-1:0] instr_o,
  output logic [DataWidth-1:0]  instr_pc_o,
  input  logic                  instr_ready_i,
  input  logic                  redirect_i,
  input  logic [DataWidth-1:0]  redirect_pc_i,
  input  logic                  trap_i,
  input  logic                  halt_i,
  output logic                  halted_o,
  output fetch_state_e          dbg_state_o
);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  fetch_state_e          r_state;
  logic                  r_kill;      // in-flight fetch belongs to a flushed path
  logic                  r_req;
  logic                  r_valid;
  logic [InstrWidth-1:0] r_instr;
  logic [DataWidth-1:0]  r_instr_pc;
  logic                  r_halted;

  // ---------------------------------------------------------------------------
  // Next-PC datapath
  // ---------------------------------------------------------------------------
  logic                 w_evt;        // trap or redirect this cycle
  logic [DataWidth-1:0] w_evt_tgt;    // trap > redirect, word aligned
  logic [DataWidth-1:0] w_seq_pc;
  logic [DataWidth-1:0] w_pc_q;
  logic [DataWidth-1:0] w_pc_d;
  logic                 w_pc_load;
  logic [DataWidth-1:0] w_tgt_q;
  logic                 w_tgt_load;
  logic                 w_drop;       // response in WAIT that must be discarded

  always_comb begin
    w_evt     = trap_i | redirect_i;
    w_evt_tgt = trap_i ? TrapVector : {redirect_pc_i[DataWidth-1:2], 2'b00};
    // Plain modular add: 0xFFFF_FFFC + 4 wraps to zero.
    w_seq_pc  = w_pc_q + DataWidth'(PcStep);
    // A flush arriving in the same cycle as the response also kills it.
    w_drop    = (r_state == WAIT) && imem_rvalid_i && (r_kill || w_evt);

    w_pc_load = 1'b0;
    w_pc_d    = w_pc_q;
    case (r_state)
      WAIT: begin
        if (w_drop) begin
          w_pc_load = 1'b1;
          // A flush in this very cycle is the latest event, so it wins.
          w_pc_d    = w_evt ? w_evt_tgt : w_tgt_q;
        end
      end
      HOLD: begin
        if (instr_ready_i) begin
          w_pc_load = 1'b1;
          w_pc_d    = w_evt ? w_evt_tgt : w_seq_pc;
        end else if (w_evt) begin
          w_pc_load = 1'b1;
          w_pc_d    = w_evt_tgt;
        end
      end
      default: begin
        w_pc_load = 1'b0;
        w_pc_d    = w_pc_q;
      end
    endcase

    // Pending target only matters while a fetch is outstanding; later events
    // overwrite earlier ones.
    w_tgt_load = ((r_state == REQ) || (r_state == WAIT)) && w_evt;
  end

  pc_reg #(
    .DataWidth  (DataWidth),
    .ResetVector(ResetVector)
  ) u_pc (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load_i(w_pc_load),
    .d_i   (w_pc_d),
    .q_o   (w_pc_q)
  );

  pc_reg #(
    .DataWidth  (DataWidth),
    .ResetVector('0)
  ) u_pending_tgt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .load_i(w_tgt_load),
    .d_i   (w_evt_tgt),
    .q_o   (w_tgt_q)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_kill     <= 1'b0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (halt_i) begin
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end

        REQ: begin
          // The request itself is never withdrawn; a flush only marks it dead.
          if (w_evt) begin
            r_kill <= 1'b1;
          end
          if (imem_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= WAIT;
          end
        end

        WAIT: begin
          if (imem_rvalid_i) begin
            if (r_kill || w_evt) begin
              r_kill  <= 1'b0;
              r_req   <= 1'b1;
              r_state <= REQ;
            end else begin
              r_instr    <= imem_rdata_i;
              r_instr_pc <= w_pc_q;
              r_valid    <= 1'b1;
              r_state    <= HOLD;
            end
          end else if (w_evt) begin
            r_kill <= 1'b1;
          end
        end

        HOLD: begin
          if (instr_ready_i) begin
            r_valid <= 1'b0;
            if (halt_i) begin
              r_state  <= HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
            end
          end else if (w_evt) begin
            // Held instruction is on the wrong path: drop it and refetch.
            r_valid <= 1'b0;
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end

        HALTED: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
          r_kill  <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o    = r_req;
  assign imem_addr_o   = w_pc_q;
  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
  assign halted_o      = r_halted;
  assign dbg_state_o   = r_state;

endmodule : pc_fetch_sequencer

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the core: issues one request at a time to instruction memory, returns the instruction to the core with valid/ready, then advances the PC.
- Applies sequential, redirect (branch/jump) and trap next-PC selection, and supports halt.
- Sits between the core datapath and the imem port; replaces the free-running PC register.

Parameters:
DataWidth, 32, PC/address width
ResetVector, 32'h0000_0000, PC after reset
TrapVector, 32'h0000_0100, PC loaded on trap_i

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
imem_req_o  out  1  fetch request valid
imem_addr_o  out  DataWidth  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid
imem_rdata_i  in  32  response instruction
instr_valid_o  out  1  instruction available to core
instr_o  out  32  instruction
instr_pc_o  out  DataWidth  PC of instr_o
instr_ready_i  in  1  core consumes instruction
redirect_i  in  1  taken branch/jump
redirect_pc_i  in  DataWidth  redirect target
trap_i  in  1  trap request
halt_i  in  1  stop fetching
halted_o  out  1  sequencer halted

Behaviour:
- Reset (rst_ni low, async): state IDLE; pc = ResetVector; imem_req_o=0, imem_addr_o=ResetVector, instr_valid_o=0, instr_o=0, instr_pc_o=0, halted_o=0, kill flag=0, pending-target register cleared.
- States: IDLE, REQ, WAIT, HOLD, HALTED.
- IDLE: lasts exactly one cycle after reset release, then REQ. First imem_req_o is therefore high in the 2nd posedge-cycle after deassertion.
- REQ: imem_req_o=1, imem_addr_o=pc. Address is held stable until imem_gnt_i. On gnt -> WAIT.
- WAIT: imem_req_o=0. On imem_rvalid_i:
  - kill=0: capture rdata into instr_o and pc into instr_pc_o -> HOLD.
  - kill=1: discard the response, pc = pending target, clear kill -> REQ.
- HOLD: instr_valid_o=1; instr_o and instr_pc_o are stable until handshake.
  - Handshake = instr_valid_o & instr_ready_i.
  - On handshake: next pc = TrapVector if trap_i, else redirect_pc_i if redirect_i, else pc+4. Then -> HALTED if halt_i, else REQ.
  - No handshake: hold.
- Next-PC priority: trap_i > redirect_i > sequential.
  - Redirect target has bits[1:0] forced to 0.
  - pc+4 wraps modulo 2^DataWidth (0xFFFF_FFFC -> 0x0000_0000).
- trap_i or redirect_i in REQ or WAIT (speculative-fetch flush):
  - Set kill=1 and latch the target per the same priority; the later of several events wins.
  - The outstanding request still completes; its response is discarded.
  - The request address never changes while imem_req_o=1 and gnt is low.
- redirect_i/trap_i in HOLD without instr_ready_i: drop instr_valid_o next cycle, discard the held instruction, pc = target -> REQ.
- halt_i in REQ/WAIT is ignored; sampled only at the HOLD handshake or in IDLE (IDLE+halt_i -> HALTED).
- HALTED: halted_o=1, no requests, instr_valid_o=0. Exit only via reset.
- At most one outstanding imem transaction at any time.
- imem_rvalid_i outside WAIT is ignored.
- Reset mid-transaction: all state cleared asynchronously. A late rvalid arriving after reset (in IDLE/REQ) is ignored.

Decomposition:
- Package fetch_pkg: fetch_state_e enum {IDLE, REQ, WAIT, HOLD, HALTED}; InstrWidth=32; PcStep=4; NopInstr=32'h0000_0013.
- Sub-module pc_reg: DataWidth-parameterised register with async active-low reset to ResetVector and load enable. Holds pc and pending target.

Test Plan:
- Reset release, gnt the same cycle as req, rvalid one cycle later with 32'h0000_0013, ready=1 -> addrs 0x0, 0x4, 0x8 issued; instr_pc_o tracks 0x0, 0x4.
- redirect_i=1 with redirect_pc_i=0x0000_0203 at HOLD handshake -> next imem_addr_o=0x0000_0200.
- trap_i and redirect_i during WAIT -> response with 0xDEADBEEF is discarded (instr_valid_o stays 0); next address 0x0000_0100.
- pc=0xFFFF_FFFC, sequential handshake -> next imem_addr_o=0x0000_0000.
- ready held low 5 cycles in HOLD -> instr_o/instr_pc_o stable, no new req; halt_i with handshake -> halted_o=1, imem_req_o stays 0 for 20 cycles.
- rst_ni pulsed low in WAIT, rvalid arrives during IDLE -> ignored; first request after release is to ResetVector.
